backprop_cost_seq: RTL

Sequencer feeding the `backprop_cost` unit. It accepts (y, label) element pairs serially over a valid/ready handshake and packs SIZE of them into the `y_stream`/`label_stream` vectors. It then fires the cost unit, waits its latency, and captures the returned `cost`. Per-sample costs are accumulated over a batch of BATCH samples, and the batch total is presented on a valid/ready output toward the weight-update logic.

---
 rtl/backprop_pkg.sv | 19 +
 rtl/backprop_cost_seq_stream_packer.sv | 32 +++
 rtl/backprop_cost_seq.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/backprop_pkg.sv
// Shared types and defaults for the backprop cost sequencer and cost unit.
package backprop_pkg;

    localparam int unsigned DEFAULT_DATA_SIZE = 4;
    localparam int unsigned DEFAULT_SIZE      = 3;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        WAIT = 2'd1,
        ACC  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/backprop_cost_seq_stream_packer.sv
// stream_packer: writes one (y, label) element pair into the packed stream registers.
module stream_packer #(
    parameter int unsigned DATA_SIZE = backprop_pkg::DEFAULT_DATA_SIZE,
    parameter int unsigned SIZE      = backprop_pkg::DEFAULT_SIZE,
    parameter int unsigned IDX_W     = backprop_pkg::cnt_w(SIZE)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_en,
    input  logic [IDX_W-1:0]          idx,
    input  logic [DATA_SIZE-1:0]      y,
    input  logic [DATA_SIZE-1:0]      label,
    output logic [DATA_SIZE*SIZE-1:0] y_stream,
    output logic [DATA_SIZE*SIZE-1:0] label_stream
);

    // Element 0 lands in the most significant slice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_stream     <= '0;
            label_stream <= '0;
        end else if (wr_en) begin
            for (int unsigned i = 0; i < SIZE; i++) begin
                if (idx == IDX_W'(i)) begin
                    y_stream[DATA_SIZE*(SIZE-i)-1 -: DATA_SIZE]     <= y;
                    label_stream[DATA_SIZE*(SIZE-i)-1 -: DATA_SIZE] <= label;
                end
            end
        end
    end

endmodule

// File: rtl/backprop_cost_seq.sv
// Sequencer that packs element pairs for backprop_cost, accumulates per-sample costs
// over a batch and hands the total downstream. Define BATCH_MEAN_EN to output the mean.
module backprop_cost_seq #(
    parameter int unsigned DATA_SIZE = backprop_pkg::DEFAULT_DATA_SIZE,
    parameter int unsigned SIZE      = backprop_pkg::DEFAULT_SIZE,
    parameter int unsigned BATCH     = 4,
    parameter int unsigned COST_LAT  = 1,
    localparam int unsigned ACC_W    = DATA_SIZE + $clog2(BATCH) + 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_SIZE-1:0]      in_y,
    input  logic [DATA_SIZE-1:0]      in_label,
    output logic [DATA_SIZE*SIZE-1:0] y_stream,
    output logic [DATA_SIZE*SIZE-1:0] label_stream,
    input  logic [DATA_SIZE-1:0]      cost,
    output logic [ACC_W-1:0]          batch_cost,
    output logic                      batch_valid,
    input  logic                      batch_ready,
    output logic                      busy
);
    import backprop_pkg::*;

    localparam int unsigned EW    = cnt_w(SIZE);
    localparam int unsigned LW    = cnt_w(COST_LAT + 1);
    localparam int unsigned SW    = cnt_w(BATCH);
    localparam int unsigned SHIFT = $clog2(BATCH);

`ifdef BATCH_MEAN_EN
    if ((BATCH & (BATCH - 1)) != 0) begin : g_batch_pow2
        $error("BATCH must be a power of 2 when BATCH_MEAN_EN is defined");
    end
`endif

    state_t            state, state_nx;
    logic [EW-1:0]     elem_cnt;
    logic [LW-1:0]     lat_cnt;
    logic [SW-1:0]     samp_cnt;
    logic [ACC_W-1:0]  acc;
    logic              in_fire, out_fire, last_elem, last_samp;

    assign in_fire   = in_valid && in_ready;
    assign out_fire  = batch_valid && batch_ready;
    assign last_elem = (elem_cnt == EW'(SIZE - 1));
    assign last_samp = (samp_cnt == SW'(BATCH - 1));

    stream_packer #(
        .DATA_SIZE (DATA_SIZE),
        .SIZE      (SIZE),
        .IDX_W     (EW)
    ) u_packer (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (in_fire),
        .idx          (elem_cnt),
        .y            (in_y),
        .label        (in_label),
        .y_stream     (y_stream),
        .label_stream (label_stream)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= LOAD;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            LOAD: if (in_fire && last_elem) state_nx = WAIT;
            WAIT: if (lat_cnt == '0) state_nx = ACC;
            ACC:  state_nx = last_samp ? DONE : LOAD;
            DONE: if (out_fire) state_nx = LOAD;
            default: state_nx = LOAD;
        endcase
    end

    always_comb begin
        in_ready    = 1'b0;
        batch_valid = 1'b0;
        busy        = 1'b1;
        case (state)
            LOAD: begin
                in_ready = 1'b1;
                busy     = !((elem_cnt == '0) && (samp_cnt == '0));
            end
            DONE:    batch_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            elem_cnt <= '0;
            lat_cnt  <= '0;
            samp_cnt <= '0;
            acc      <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (in_fire) begin
                        if (last_elem) begin
                            elem_cnt <= '0;
                            lat_cnt  <= LW'(COST_LAT);
                        end else begin
                            elem_cnt <= elem_cnt + EW'(1);
                        end
                    end
                end
                WAIT: begin
                    if (lat_cnt != '0) lat_cnt <= lat_cnt - LW'(1);
                end
                ACC: begin
                    acc      <= acc + ACC_W'(cost);
                    samp_cnt <= samp_cnt + SW'(1);
                end
                DONE: begin
                    if (out_fire) begin
                        acc      <= '0;
                        samp_cnt <= '0;
                        elem_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // acc only changes in ACC and is cleared on the output handshake, so it is
    // stable for the whole DONE state and can drive the output directly.
    always_comb begin
`ifdef BATCH_MEAN_EN
        batch_cost = acc >> SHIFT;
`else
        batch_cost = acc;
`endif
    end

endmodule
